// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic number generator bank:
// LFSR tap masks, step function, per-channel seed derivation and FSM states.
package sc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Tap masks for the maximal-length Fibonacci LFSRs, one per legal width
    localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_W16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_W24 = 32'h00E1_0000;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

    function automatic logic [31:0] taps_of(input int unsigned width);
        case (width)
            32'd8:   return TAPS_W8;
            32'd24:  return TAPS_W24;
            32'd32:  return TAPS_W32;
            default: return TAPS_W16;
        endcase
    endfunction

    function automatic logic [31:0] width_mask(input int unsigned width);
        if (width >= 32'd32) return '1;
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic logic [31:0] lfsr_next(input int unsigned width, input logic [31:0] s);
        logic fb;
        fb = ^(s & taps_of(width));
        return ((s << 1) | {31'd0, fb}) & width_mask(width);
    endfunction

    // Zero is the LFSR lock-up state, so a seed that wraps to 0 is forced to 1
    function automatic logic [31:0] seed_of(input int unsigned width, input logic [31:0] seed,
                                            input logic [31:0] step, input int unsigned k);
        logic [31:0] s;
        s = (seed + step * 32'(k)) & width_mask(width);
        if (s == 32'd0) s = 32'd1;
        return s;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// One Fibonacci LFSR channel; reseeds to its fixed seed on reset or reseed_i.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int unsigned          WIDTH    = 16,
    parameter logic [WIDTH-1:0]     SEED_VAL = WIDTH'(1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             reseed_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || reseed_i) begin
            q_o <= SEED_VAL;
        end else if (step_i) begin
            q_o <= WIDTH'(lfsr_next(WIDTH, 32'(q_o)));
        end
    end

endmodule

// File: rtl/sc_sng_bank.sv
// Multi-channel stochastic number generator with valid/ready stream output.
// Optional SC_ONES_COUNT_EN adds per-channel ones counters on cnt_o.
module sc_sng_bank
    import sc_pkg::*;
#(
    parameter int unsigned  WIDTH      = 16,
    parameter int unsigned  CHANNELS   = 4,
    parameter int unsigned  STREAM_LEN = 65535,
    parameter logic [31:0]  SEED       = 32'h0000ACE1,
    parameter logic [31:0]  SEED_STEP  = 32'h00003C5B
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_valid_i,
    output logic                         load_ready_o,
    input  logic [CHANNELS*WIDTH-1:0]    in_i,
    input  logic                         abort_i,
    output logic                         d_valid_o,
    input  logic                         d_ready_i,
    output logic [CHANNELS-1:0]          d_o,
`ifdef SC_ONES_COUNT_EN
    output logic [CHANNELS*$clog2(64'(STREAM_LEN) + 64'd1)-1:0] cnt_o,
`endif
    output logic                         last_o
);

    localparam int unsigned     CW       = $clog2(64'(STREAM_LEN) + 64'd1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(STREAM_LEN - 32'd1);

    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
        $error("sc_sng_bank: WIDTH must be 8, 16, 24 or 32");
    end

    state_e                          state_q;
    logic                            load_ready_q;
    logic                            d_valid_q;
    logic [CW-1:0]                   cnt_q;
    logic [CHANNELS*WIDTH-1:0]       val_q;
    logic [CHANNELS-1:0][WIDTH-1:0]  lfsr_q;
    logic [CHANNELS-1:0]             bits_c;
    logic                            load_acc_c;
    logic                            beat_acc_c;

    assign load_acc_c = load_ready_q & load_valid_i;
    // An aborted beat is not a transfer even if the consumer is ready
    assign beat_acc_c = d_valid_q & d_ready_i & ~abort_i;

    for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_lfsr
        sc_lfsr #(
            .WIDTH    (WIDTH),
            .SEED_VAL (WIDTH'(seed_of(WIDTH, SEED, SEED_STEP, 32'(k))))
        ) u_lfsr (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .reseed_i (load_acc_c),
            .step_i   (beat_acc_c),
            .q_o      (lfsr_q[k])
        );
    end

    // Unipolar comparison: over a full LFSR period exactly val ones are produced
    always_comb begin
        bits_c = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            bits_c[k] = (lfsr_q[k] <= val_q[k*WIDTH +: WIDTH]);
        end
    end

    assign load_ready_o = load_ready_q;
    assign d_valid_o    = d_valid_q;
    assign d_o          = d_valid_q ? bits_c : '0;
    assign last_o       = d_valid_q && (cnt_q == LAST_IDX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            load_ready_q <= 1'b1;
            d_valid_q    <= 1'b0;
            cnt_q        <= '0;
            val_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid_i) begin
                        val_q        <= in_i;
                        cnt_q        <= '0;
                        state_q      <= RUN;
                        load_ready_q <= 1'b0;
                        d_valid_q    <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_i || (d_ready_i && cnt_q == LAST_IDX)) begin
                        state_q      <= IDLE;
                        load_ready_q <= 1'b1;
                        d_valid_q    <= 1'b0;
                    end
                    if (beat_acc_c) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

`ifdef SC_ONES_COUNT_EN
    for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_ones
        logic [CW-1:0] ones_q;
        always_ff @(posedge clk_i) begin
            if (rst_i || load_acc_c) begin
                ones_q <= '0;
            end else if (beat_acc_c && bits_c[k]) begin
                ones_q <= ones_q + CW'(1);
            end
        end
        assign cnt_o[k*CW +: CW] = ones_q;
    end
`endif

endmodule

// File: tb/tb_sc_sng_bank.sv
// Scoreboard bench for sc_sng_bank: driver pushes model beats, monitor pops and compares.
module tb_sc_sng_bank;

    localparam int unsigned W   = 16;
    localparam int unsigned CH  = 4;
    localparam int unsigned LEN = 65535;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            load_valid_i = 1'b0;
    logic            load_ready_o;
    logic [CH*W-1:0] in_i = '0;
    logic            abort_i = 1'b0;
    logic            d_valid_o;
    logic            d_ready_i = 1'b0;
    logic [CH-1:0]   d_o;
    logic            last_o;
`ifdef SC_ONES_COUNT_EN
    logic [CH*16-1:0] cnt_o;
`endif

    sc_sng_bank #(.WIDTH(W), .CHANNELS(CH), .STREAM_LEN(LEN)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .in_i         (in_i),
        .abort_i      (abort_i),
        .d_valid_o    (d_valid_o),
        .d_ready_i    (d_ready_i),
        .d_o          (d_o),
`ifdef SC_ONES_COUNT_EN
        .cnt_o        (cnt_o),
`endif
        .last_o       (last_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [4:0]  exp_q[$];
    int          ones[CH];
    logic [15:0] m_lfsr[CH];
    logic [15:0] m_val[CH];
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] m_seed(input int k);
        logic [15:0] s;
        s = 16'(32'hACE1 + 32'(k) * 32'h3C5B);
        if (s == 16'd0) s = 16'd1;
        return s;
    endfunction

    task automatic model_load(input logic [63:0] words);
        for (int k = 0; k < int'(CH); k++) begin
            m_lfsr[k] = m_seed(k);
            m_val[k]  = words[16*k +: 16];
        end
        m_cnt = 0;
    endtask

    task automatic push_beat();
        logic [4:0] e;
        for (int k = 0; k < int'(CH); k++) begin
            e[k]      = (m_lfsr[k] <= m_val[k]);
            m_lfsr[k] = m_step(m_lfsr[k]);
        end
        e[4] = (m_cnt == int'(LEN) - 1);
        m_cnt++;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] words);
        int guard = 0;
        d_ready_i = 1'b0;
        while (!load_ready_o && guard < 20) begin
            tick();
            guard++;
        end
        check("load_ready_before_load", 32'(load_ready_o), 32'd1);
        in_i = words;
        load_valid_i = 1'b1;
        tick();
        load_valid_i = 1'b0;
        model_load(words);
        check("d_valid_after_load", 32'(d_valid_o), 32'd1);
        check("load_ready_in_run", 32'(load_ready_o), 32'd0);
    endtask

    task automatic run_beats(input int n, input int stall_pct);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < n * 20 + 100) begin
            if (int'($urandom_range(99)) < stall_pct) begin
                d_ready_i = 1'b0;
            end else begin
                d_ready_i = 1'b1;
                push_beat();
                acc++;
            end
            tick();
            cyc++;
        end
        d_ready_i = 1'b0;
        check("beats_issued", 32'(acc), 32'(n));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_abort();
        abort_i   = 1'b1;
        d_ready_i = 1'b1;
        tick();
        abort_i   = 1'b0;
        d_ready_i = 1'b0;
        check("abort_load_ready", 32'(load_ready_o), 32'd1);
        check("abort_d_valid", 32'(d_valid_o), 32'd0);
    endtask

    // Monitor: compare every accepted beat, and d_o stability across stalls
    initial begin
        logic [4:0]    e;
        logic          stalled = 1'b0;
        logic [CH-1:0] prev_d  = '0;
        forever begin
            @(negedge clk);
            if (!rst_i && stalled && d_valid_o)
                check("stall_hold", 32'(d_o), 32'(prev_d));
            if (!rst_i && d_valid_o && d_ready_i && !abort_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_d", 32'(d_o), 32'(e[3:0]));
                    check("beat_last", 32'(last_o), 32'(e[4]));
                end
                for (int k = 0; k < int'(CH); k++) ones[k] += int'(d_o[k]);
            end
            stalled = !rst_i && d_valid_o && !d_ready_i && !abort_i;
            prev_d  = d_o;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] WORDS_EX = {16'h0001, 16'hFFFF, 16'h0000, 16'h7FFF};
    localparam logic [63:0] WORDS_A  = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    localparam logic [63:0] WORDS_B  = {16'h2000, 16'hC000, 16'h4000, 16'h8000};

    initial begin
        for (int k = 0; k < int'(CH); k++) ones[k] = 0;
        repeat (3) tick();
        check("rst_load_ready", 32'(load_ready_o), 32'd1);
        check("rst_d_valid", 32'(d_valid_o), 32'd0);
        check("rst_last", 32'(last_o), 32'd0);
        check("rst_d", 32'(d_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Abort in IDLE is ignored
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("idle_abort_ready", 32'(load_ready_o), 32'd1);
        check("idle_abort_valid", 32'(d_valid_o), 32'd0);

        // First beat compares against seed 0xACE1
        do_load(64'h0000_0000_0000_ACE1);
        check("first_beat_eq_seed", 32'(d_o[0]), 32'd1);
        do_abort();
        do_load(64'h0000_0000_0000_ACE0);
        check("first_beat_below_seed", 32'(d_o[0]), 32'd0);
        do_abort();

        // Load and abort together in IDLE: load wins
        in_i = WORDS_A;
        load_valid_i = 1'b1;
        abort_i = 1'b1;
        tick();
        load_valid_i = 1'b0;
        abort_i = 1'b0;
        model_load(WORDS_A);
        check("load_beats_abort_valid", 32'(d_valid_o), 32'd1);
        run_beats(5, 0);
        do_abort();

        // Full-period exactness
        do_load(WORDS_EX);
        for (int k = 0; k < int'(CH); k++) ones[k] = 0;
        run_beats(int'(LEN), 0);
        check("end_load_ready", 32'(load_ready_o), 32'd1);
        check("end_d_valid", 32'(d_valid_o), 32'd0);
        check("end_last", 32'(last_o), 32'd0);
        check("ones_ch0", 32'(ones[0]), 32'd32767);
        check("ones_ch1", 32'(ones[1]), 32'd0);
        check("ones_ch2", 32'(ones[2]), 32'd65535);
        check("ones_ch3", 32'(ones[3]), 32'd1);
`ifdef SC_ONES_COUNT_EN
        check("cnt_o_ch0", 32'(cnt_o[0 +: 16]), 32'd32767);
        check("cnt_o_ch1", 32'(cnt_o[16 +: 16]), 32'd0);
        check("cnt_o_ch2", 32'(cnt_o[32 +: 16]), 32'd65535);
        check("cnt_o_ch3", 32'(cnt_o[48 +: 16]), 32'd1);
`endif

        // Load attempt mid-stream is ignored
        do_load(WORDS_A);
        run_beats(10, 0);
        in_i = WORDS_B;
        load_valid_i = 1'b1;
        check("run_load_ready", 32'(load_ready_o), 32'd0);
        run_beats(1, 0);
        load_valid_i = 1'b0;
        run_beats(20, 0);
        do_abort();

        // Abort at beat 500, reload restarts the identical stream
        do_load(WORDS_B);
        run_beats(500, 0);
        do_abort();
        do_load(WORDS_B);
        run_beats(1000, 0);
        do_abort();

        // Random backpressure gives the same stream as the stall-free run
        do_load(WORDS_B);
        run_beats(1000, 50);
        do_abort();

        // Reset mid-stream
        do_load(WORDS_A);
        run_beats(300, 0);
        rst_i = 1'b1;
        tick();
        check("midrst_d_valid", 32'(d_valid_o), 32'd0);
        check("midrst_load_ready", 32'(load_ready_o), 32'd1);
        check("midrst_last", 32'(last_o), 32'd0);
        check("midrst_d", 32'(d_o), 32'd0);
`ifdef SC_ONES_COUNT_EN
        check("midrst_cnt_o", 32'(cnt_o != '0), 32'd0);
`endif
        rst_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
